// File: rtl/sram_64x7_port_ctrl.sv
// sram_64x7_port_ctrl
// Owns the single read/write port of the 64x7 SRAM macro. After reset it
// optionally sweeps the array to INIT_VALUE, then accepts read and masked-write
// requests and buffers the macro's registered read data for the consumer.
//
// Handshake semantics:
//   request  : a request transfers on any cycle where req_v_in && req_ready_out.
//              req_ready_out never depends on req_v_in or req_w_in, but does
//              depend combinationally on rsp_yumi_in (a pop frees a slot).
//   response : rsp_v_out/rsp_data_out present the oldest buffered read. The
//              head holds stable until the consumer asserts rsp_yumi_in, which
//              is only meaningful while rsp_v_out=1.
module sram_64x7_port_ctrl #(
   parameter int                 BITS          = 7,
   parameter int                 WORD_DEPTH    = 64,
   parameter int                 ADDR_WIDTH    = 6,
   parameter int                 INIT_ON_RESET = 1,
   parameter logic [BITS-1:0]    INIT_VALUE    = '0
) (
   input  logic                  clk,
   input  logic                  reset_n_in,
   input  logic                  req_v_in,
   output logic                  req_ready_out,
   input  logic                  req_w_in,
   input  logic [ADDR_WIDTH-1:0] req_addr_in,
   input  logic [BITS-1:0]       req_data_in,
   input  logic [BITS-1:0]       req_mask_in,
   output logic                  rsp_v_out,
   output logic [BITS-1:0]       rsp_data_out,
   input  logic                  rsp_yumi_in,
   output logic                  init_done_out,
   output logic                  sram_ce_out,
   output logic                  sram_we_out,
   output logic [ADDR_WIDTH-1:0] sram_addr_out,
   output logic [BITS-1:0]       sram_wd_out,
   output logic [BITS-1:0]       sram_w_mask_out,
   input  logic [BITS-1:0]       sram_rd_in
);

   localparam bit DO_SWEEP = (INIT_ON_RESET != 0);

   typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

   state_t                state_q;
   state_t                state_d;
   logic [ADDR_WIDTH-1:0] cnt_q;
   logic                  sweep_last;

   // Response buffer: two-entry FIFO plus one read in flight inside the macro.
   logic [BITS-1:0]       buf_mem [2];
   logic                  wr_ptr_q;
   logic                  rd_ptr_q;
   logic [1:0]            count_q;
   logic                  inflight_q;
   logic                  push;
   logic                  pop;
   logic [2:0]            occ;
   logic [2:0]            occ_after_pop;
   logic                  accept;

   assign sweep_last    = (cnt_q == ADDR_WIDTH'(WORD_DEPTH - 1));
   assign rsp_v_out     = (count_q != 2'd0);
   assign rsp_data_out  = rsp_v_out ? buf_mem[rd_ptr_q] : '0;
   assign init_done_out = (state_q == ST_RUN);
   assign push          = inflight_q;
   assign pop           = rsp_v_out && rsp_yumi_in;
   // The in-flight read already owns a slot, so it counts toward occupancy.
   assign occ           = {1'b0, count_q} + {2'b00, inflight_q};
   assign occ_after_pop = occ - {2'b00, pop};

   // State register: reset always returns to INIT.
   always_ff @(posedge clk) begin
      if (!reset_n_in) state_q <= ST_INIT;
      else             state_q <= state_d;
   end

   // Next state: leave INIT after the last sweep write, or at once when the sweep is disabled.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_INIT: if (!DO_SWEEP || sweep_last) state_d = ST_RUN;
         ST_RUN:  state_d = ST_RUN;
         default: state_d = ST_INIT;
      endcase
   end

   // Sweep address counter: restarts at 0 on every reset, advances one word per INIT cycle.
   always_ff @(posedge clk) begin
      if (!reset_n_in)                      cnt_q <= '0;
      else if (state_q == ST_INIT && DO_SWEEP) cnt_q <= cnt_q + ADDR_WIDTH'(1);
   end

   // Outputs: request ready plus macro pins, driven by the sweep in INIT or by an accepted request in RUN.
   always_comb begin
      req_ready_out   = 1'b0;
      accept          = 1'b0;
      sram_ce_out     = 1'b0;
      sram_we_out     = 1'b0;
      sram_addr_out   = '0;
      sram_wd_out     = '0;
      sram_w_mask_out = '0;
      case (state_q)
         ST_INIT: begin
            if (DO_SWEEP && reset_n_in) begin
               sram_ce_out     = 1'b1;
               sram_we_out     = 1'b1;
               sram_addr_out   = cnt_q;
               sram_wd_out     = INIT_VALUE;
               sram_w_mask_out = '1;
            end
         end
         ST_RUN: begin
            req_ready_out = reset_n_in && (occ_after_pop < 3'd2);
            accept        = req_v_in && req_ready_out;
            if (accept) begin
               sram_ce_out     = 1'b1;
               sram_we_out     = req_w_in;
               sram_addr_out   = req_addr_in;
               sram_wd_out     = req_w_in ? req_data_in : '0;
               sram_w_mask_out = req_w_in ? req_mask_in : '0;
            end
         end
         default: ;
      endcase
   end

   // Buffer control: flag a read in flight, then push the macro data the following cycle.
   always_ff @(posedge clk) begin
      if (!reset_n_in) begin
         inflight_q <= 1'b0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
      end else begin
         inflight_q <= accept && !req_w_in;
         if (push) wr_ptr_q <= ~wr_ptr_q;
         if (pop)  rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   // Buffer storage: data only, validity is tracked by count_q.
   always_ff @(posedge clk) begin
      if (push) buf_mem[wr_ptr_q] <= sram_rd_in;
   end

endmodule

// File: tb/tb_sram_64x7_port_ctrl.sv
// Bench for sram_64x7_port_ctrl with a behavioural model of the macro.
module tb_sram_64x7_port_ctrl;
   localparam int BITS  = 7;
   localparam int DEPTH = 64;
   localparam int AW    = 6;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            reset_n;
   logic            req_v, req_w;
   logic [AW-1:0]   req_addr;
   logic [BITS-1:0] req_data, req_mask;
   logic            req_ready, rsp_v, rsp_yumi, init_done;
   logic [BITS-1:0] rsp_data;
   logic            sram_ce, sram_we;
   logic [AW-1:0]   sram_addr;
   logic [BITS-1:0] sram_wd, sram_w_mask, sram_rd;
   logic            yumi_en;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Consumer only takes a response that is actually presented.
   assign rsp_yumi = yumi_en & rsp_v;

   sram_64x7_port_ctrl dut (
      .clk             (clk),
      .reset_n_in      (reset_n),
      .req_v_in        (req_v),
      .req_ready_out   (req_ready),
      .req_w_in        (req_w),
      .req_addr_in     (req_addr),
      .req_data_in     (req_data),
      .req_mask_in     (req_mask),
      .rsp_v_out       (rsp_v),
      .rsp_data_out    (rsp_data),
      .rsp_yumi_in     (rsp_yumi),
      .init_done_out   (init_done),
      .sram_ce_out     (sram_ce),
      .sram_we_out     (sram_we),
      .sram_addr_out   (sram_addr),
      .sram_wd_out     (sram_wd),
      .sram_w_mask_out (sram_w_mask),
      .sram_rd_in      (sram_rd)
   );

   // Macro model: masked write, registered read data.
   logic [BITS-1:0] macro_mem [DEPTH];
   always @(posedge clk) begin
      if (sram_ce && sram_we)
         macro_mem[sram_addr] <= (macro_mem[sram_addr] & ~sram_w_mask) | (sram_wd & sram_w_mask);
      if (sram_ce && !sram_we)
         sram_rd <= macro_mem[sram_addr];
   end

   // ---------------- scoreboard ----------------
   logic [BITS-1:0] exp_q[$];
   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every consumed response is matched against the oldest expected read.
   always @(negedge clk) begin
      if (rsp_v === 1'b1 && rsp_yumi === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL rsp_unexpected: got data %0h, required no response (cycle %0d)", rsp_data, cyc);
         end else begin
            check("rsp_data", 32'(rsp_data), 32'(exp_q.pop_front()));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle();
      req_v = 1'b0; req_w = 1'b0; req_addr = '0; req_data = '0; req_mask = '0;
   endtask

   // Holds the request until accepted; checks the macro pins on the accept cycle.
   task automatic do_req(input logic w, input logic [AW-1:0] a, input logic [BITS-1:0] d,
                         input logic [BITS-1:0] m, input logic [BITS-1:0] exp_rd);
      bit done = 1'b0;
      req_v = 1'b1; req_w = w; req_addr = a; req_data = d; req_mask = m;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (req_ready === 1'b1) begin
            check("accept_pins", 32'({sram_ce, sram_we, sram_addr, sram_wd, sram_w_mask}),
                  32'({1'b1, w, a, (w ? d : 7'h00), (w ? m : 7'h00)}));
            @(posedge clk);
            if (!w) exp_q.push_back(exp_rd);
            done = 1'b1;
            #1;
         end
      end
      if (!done) begin
         n_vec++;
         n_err++;
         $display("FAIL accept_timeout: request addr %0h never accepted, required accept within 200 cycles", a);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      check("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   // Called in cycle 1 after reset release; checks 64 sweep writes then RUN entry.
   task automatic check_sweep();
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         check("sweep_pins",
               32'({sram_ce, sram_we, sram_addr, sram_wd, sram_w_mask, req_ready, rsp_v, init_done}),
               32'({2'b11, 6'(i), 7'h00, 7'h7F, 3'b000}));
         @(posedge clk); #1;
      end
      @(negedge clk);
      check("init_done_ready", 32'({init_done, req_ready}), 32'd3);
      @(posedge clk); #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int start_cyc;
      reset_n = 1'b0;
      yumi_en = 1'b0;
      idle();

      // Reset low for two cycles, check reset state after the first edge.
      @(posedge clk);
      @(negedge clk);
      check("reset_state",
            32'({req_ready, rsp_v, rsp_data, init_done, sram_ce, sram_we, sram_addr, sram_wd, sram_w_mask}),
            32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      check_sweep();

      // Idle in RUN: macro pins quiet.
      @(negedge clk);
      check("idle_pins", 32'({sram_ce, sram_we, sram_addr, sram_wd, sram_w_mask}), 32'd0);
      @(posedge clk); #1;

      yumi_en = 1'b1;
      // Last swept word reads back as zero.
      do_req(1'b0, 6'd63, 7'h00, 7'h00, 7'h00);
      idle();
      drain();

      // Write then read in the next cycle; response two cycles after accept.
      do_req(1'b1, 6'd5, 7'h55, 7'h7F, 7'h00);
      do_req(1'b0, 6'd5, 7'h00, 7'h00, 7'h55);
      idle();
      @(negedge clk);
      check("latency_t1_rsp_v", 32'(rsp_v), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("latency_t2_rsp_v", 32'(rsp_v), 32'd1);
      @(posedge clk); #1;
      drain();

      // Masked write: 0x55 with low nibble forced to F gives 0x5F.
      do_req(1'b1, 6'd5, 7'h7F, 7'h0F, 7'h00);
      do_req(1'b0, 6'd5, 7'h00, 7'h00, 7'h5F);
      idle();
      drain();

      // Stalled consumer: two reads outstanding, third waits until a yumi frees space.
      do_req(1'b1, 6'd1, 7'h11, 7'h7F, 7'h00);
      do_req(1'b1, 6'd2, 7'h22, 7'h7F, 7'h00);
      do_req(1'b1, 6'd3, 7'h33, 7'h7F, 7'h00);
      yumi_en = 1'b0;
      do_req(1'b0, 6'd1, 7'h00, 7'h00, 7'h11);
      do_req(1'b0, 6'd2, 7'h00, 7'h00, 7'h22);
      req_v = 1'b1; req_w = 1'b0; req_addr = 6'd3;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("stall_ready", 32'(req_ready), 32'd0);
         check("stall_head", 32'({rsp_v, rsp_data}), 32'({1'b1, 7'h11}));
         @(posedge clk); #1;
      end
      yumi_en = 1'b1;
      @(negedge clk);
      check("yumi_frees_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      exp_q.push_back(7'h33);
      #1;
      idle();
      drain();

      // Fill the array with addr^0x2A, then stream 64 reads with yumi held high.
      for (int a = 0; a < DEPTH; a++)
         do_req(1'b1, 6'(a), 7'(a ^ 'h2A), 7'h7F, 7'h00);
      start_cyc = cyc;
      for (int a = 0; a < DEPTH; a++)
         do_req(1'b0, 6'(a), 7'h00, 7'h00, 7'(a ^ 'h2A));
      check("stream_cycles", 32'(cyc - start_cyc), 32'd64);
      idle();
      drain();

      // Reset in the cycle after a read is accepted: response dropped, sweep restarts.
      do_req(1'b0, 6'd9, 7'h00, 7'h00, 7'h23);
      idle();
      reset_n = 1'b0;
      exp_q.delete();
      @(posedge clk); #1;
      reset_n = 1'b1;
      check_sweep();
      do_req(1'b0, 6'd5, 7'h00, 7'h00, 7'h00);
      do_req(1'b0, 6'd9, 7'h00, 7'h00, 7'h00);
      idle();
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sram_64x7_port_ctrl.md
# sram_64x7_port_ctrl

Request-side controller for the 64x7 hard SRAM macro: it owns the macro's single read/write port. It accepts read and masked-write requests over a ready/valid interface, drives the macro pins, and captures the macro's registered read data into a response buffer with valid/yumi handoff. After every reset it optionally sweeps the array to a known value before it accepts traffic. Front-end metadata tables instantiate it between their lookup/update logic and the macro.

## Interface
Parameters:
- BITS, 7, data word width
- WORD_DEPTH, 64, number of words
- ADDR_WIDTH, 6, address width (log2 WORD_DEPTH)
- INIT_ON_RESET, 1, 1 = clear the array after reset; 0 = skip the sweep
- INIT_VALUE, 0, BITS-wide word written during the sweep

Ports:
- clk  in  1  sole clock, rising edge
- reset_n_in  in  1  synchronous, active-low reset
- req_v_in  in  1  request valid
- req_ready_out  out  1  request ready
- req_w_in  in  1  1 = write, 0 = read
- req_addr_in  in  ADDR_WIDTH  word address
- req_data_in  in  BITS  write data
- req_mask_in  in  BITS  write bit-enable, active-high
- rsp_v_out  out  1  read response valid
- rsp_data_out  out  BITS  read response data
- rsp_yumi_in  in  1  consumer takes the response this cycle; legal only when rsp_v_out=1
- init_done_out  out  1  sweep complete, controller is in RUN
- sram_ce_out, sram_we_out  out  1 each  macro chip enable and write enable
- sram_addr_out  out  ADDR_WIDTH  macro address
- sram_wd_out, sram_w_mask_out  out  BITS each  macro write data and bit mask
- sram_rd_in  in  BITS  macro read data, valid the cycle after a read is issued

## Operation
- FSM states: INIT and RUN. Reset forces INIT with the sweep counter at 0.
  - If INIT_ON_RESET=0, INIT moves to RUN on the first cycle after reset with no macro access.
- INIT: one write per cycle.
  - Pins: ce=1, we=1, addr=counter, wd=INIT_VALUE, mask=all ones.
  - Transition: after addr WORD_DEPTH-1 is written, go to RUN.
  - During INIT, req_ready_out=0 and rsp_v_out=0.
- RUN: a request is accepted when req_v_in && req_ready_out.
  - On accept, the macro pins are driven combinationally in the same cycle: ce=1, we=req_w_in, addr=req_addr_in, wd=req_data_in, mask=req_mask_in (wd and mask are zero on reads).
  - When no request is accepted, all sram_*_out are 0.
- Writes update only the bits whose mask bit is 1. Writes produce no response.
- Response buffer: a 2-entry in-order FIFO plus an in-flight flag.
  - A read accepted in cycle t sets the flag for cycle t+1.
  - In cycle t+1, sram_rd_in is pushed into the FIFO.
- Occupancy occ = FIFO count + in-flight flag.
- req_ready_out = RUN && (occ - (rsp_v_out && rsp_yumi_in)) < 2.
  - This applies to writes as well: writes stall while the buffer is full.
- rsp_v_out = FIFO not empty. rsp_data_out = FIFO head.
  - The head holds stable until yumi.
  - A yumi and a push in the same cycle are both honored.
- Responses return in request order. A read issued the cycle after a write to the same address returns the new data.
- Reset asserted mid-operation: on the next edge the FIFO and in-flight flag are flushed, the in-flight read is dropped, the FSM returns to INIT, and the counter returns to 0.

## Timing
- Reset values: req_ready_out=0, rsp_v_out=0, rsp_data_out=0, init_done_out=0, all sram_*_out=0.
- Sweep duration: exactly WORD_DEPTH cycles after reset deasserts.
  - init_done_out and req_ready_out rise in cycle WORD_DEPTH+1; cycle 1 is the first with reset_n_in=1.
  - With INIT_ON_RESET=0 they rise in cycle 2.
- Read latency: accept in cycle t gives rsp_v_out=1 in cycle t+2.
- Throughput: one request per cycle is sustained while rsp_yumi_in is held high.
- With the consumer stalled, at most 2 reads are outstanding; ready drops in the cycle after the second read is accepted.
- req_ready_out depends combinationally on rsp_yumi_in. It does not depend on req_v_in or req_w_in.

## Test plan
- Reset low 2 cycles, then high, INIT_ON_RESET=1 -> 64 cycles with ce=we=1, addr 0..63, wd=0, mask=7'h7F; init_done_out=1 and req_ready_out=1 in cycle 65. Then read addr 63 -> 7'h00.
- Write 7'h55 to addr 5 with mask 7'h7F, then read addr 5 in the next cycle -> rsp_v_out=1 two cycles after the read is accepted, rsp_data_out=7'h55.
- Masked write 7'h7F to addr 5 with mask 7'h0F (after 7'h55) -> a read of addr 5 returns 7'h5F.
- Reads to addr 1, 2, 3 issued back-to-back with rsp_yumi_in=0 -> only 1 and 2 are accepted, and ready stays 0. rsp_data_out holds addr 1's data stably. Pulsing yumi returns 1, 2, 3 in order, and addr 3 is accepted once space frees.
- Write addr 0..63 with value addr[5:0]^7'h2A, then stream 64 reads with yumi held at 1 -> one accept per cycle, 64 in-order correct responses, no bubble.
- Assert reset in the cycle after a read is accepted -> no response is produced, rsp_v_out=0, and the sweep restarts at addr 0 once reset releases.
